// File: rtl/fft_mul_sequencer.sv
// Control sequencer for the FFT-based large multiplier: forward FFT of A and B,
// pointwise complex multiply, inverse FFT, with pipeline drains between stages.
module fft_mul_sequencer #(
    parameter int LOG2N  = 9,
    parameter int ADDR_W = LOG2N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [1:0]        buf_sel,
    output logic              bf_inv,
    output logic              bf_valid,
    input  logic              bf_ready,
    output logic [ADDR_W-1:0] bf_top,
    output logic [ADDR_W-1:0] bf_bot,
    output logic [ADDR_W-2:0] bf_tw,
    output logic              pw_valid,
    input  logic              pw_ready,
    output logic [ADDR_W-1:0] pw_addr,
    input  logic              dp_idle,
    output logic [3:0]        stage
);

    typedef enum logic [2:0] {IDLE, FFT_A, FFT_B, PW, IFFT, DRAIN, FIN} state_e;
    // Pass remembers which phase DRAIN returns to and what buffer it drives.
    typedef enum logic [1:0] {P_A, P_B, P_PW, P_I} pass_e;

    localparam logic [3:0]       S_LAST    = 4'(LOG2N - 1);
    localparam logic [LOG2N-1:0] K_PW_LAST = '1;
    localparam logic [LOG2N-1:0] K_BF_LAST = K_PW_LAST >> 1;

    state_e            state_q, state_d;
    pass_e             pass_q, pass_d;
    logic [3:0]        s_q, s_d;
    logic [LOG2N-1:0]  k_q, k_d;

    logic [ADDR_W-1:0] kb, half, jm, top;
    logic [3:0]        tw_sh;

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pass_q  <= P_A;
            s_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            s_q     <= s_d;
            k_q     <= k_d;
        end
    end

    // NOTE: every variable gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        s_d     = s_q;
        k_d     = k_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = FFT_A;
                pass_d  = P_A;
                s_d     = '0;
                k_d     = '0;
            end
            FFT_A, FFT_B, IFFT: if (bf_ready) begin
                if (k_q == K_BF_LAST) begin
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + LOG2N'(1);
                end
            end
            PW: if (pw_ready) begin
                if (k_q == K_PW_LAST) begin
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + LOG2N'(1);
                end
            end
            DRAIN: if (dp_idle) begin
                if (pass_q != P_PW && s_q != S_LAST) begin
                    s_d = s_q + 4'd1;
                    case (pass_q)
                        P_A:     state_d = FFT_A;
                        P_B:     state_d = FFT_B;
                        default: state_d = IFFT;
                    endcase
                end else begin
                    s_d = '0;
                    case (pass_q)
                        P_A:     begin state_d = FFT_B; pass_d = P_B;  end
                        P_B:     begin state_d = PW;    pass_d = P_PW; end
                        P_PW:    begin state_d = IFFT;  pass_d = P_I;  end
                        default: state_d = FIN;
                    endcase
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In-place radix-2 addressing: top = g*2*half + j, built by shifting the group bits up one.
    always_comb begin
        kb    = ADDR_W'(k_q);
        half  = ADDR_W'(1) << s_q;
        jm    = kb & (half - ADDR_W'(1));
        top   = ((kb >> s_q) << (s_q + 4'd1)) | jm;
        tw_sh = S_LAST - s_q;
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == FIN);
        stage    = s_q;
        buf_sel  = 2'd0;
        bf_inv   = (state_q == IFFT) || (state_q == DRAIN && pass_q == P_I);
        bf_valid = 1'b0;
        bf_top   = '0;
        bf_bot   = '0;
        bf_tw    = '0;
        pw_valid = 1'b0;
        pw_addr  = '0;
        if (state_q != IDLE) begin
            case (pass_q)
                P_A:     buf_sel = 2'd0;
                P_B:     buf_sel = 2'd1;
                default: buf_sel = 2'd2;
            endcase
        end
        if (state_q == FFT_A || state_q == FFT_B || state_q == IFFT) begin
            bf_valid = 1'b1;
            bf_top   = top;
            bf_bot   = top | half;
            bf_tw    = (ADDR_W-1)'(jm << tw_sh);
        end
        if (state_q == PW) begin
            pw_valid = 1'b1;
            pw_addr  = ADDR_W'(k_q);
        end
    end

endmodule

// File: tb/tb_fft_mul_sequencer.sv
// Self-checking bench for fft_mul_sequencer at LOG2N=3: a transaction-level model
// of the whole multiply is compared against every butterfly/pointwise transfer.
module tb_fft_mul_sequencer;

    localparam int LOG2N = 3;
    localparam int N     = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          bf_ready = 1'b1;
    logic          pw_ready = 1'b1;
    logic          dp_idle = 1'b1;
    logic          busy, done, bf_inv, bf_valid, pw_valid;
    logic [1:0]    buf_sel;
    logic [AW-1:0] bf_top, bf_bot, pw_addr;
    logic [AW-2:0] bf_tw;
    logic [3:0]    stage;

    always #5 clk = ~clk;

    fft_mul_sequencer #(.LOG2N(LOG2N), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .buf_sel(buf_sel), .bf_inv(bf_inv), .bf_valid(bf_valid), .bf_ready(bf_ready),
        .bf_top(bf_top), .bf_bot(bf_bot), .bf_tw(bf_tw), .pw_valid(pw_valid),
        .pw_ready(pw_ready), .pw_addr(pw_addr), .dp_idle(dp_idle), .stage(stage)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    typedef struct {
        bit is_pw;
        int top;
        int bot;
        int tw;
        int addr;
        int sel;
        int inv;
    } txn_t;

    txn_t exp_q[$];
    txn_t log_q[$];
    int   trace_q[$];

    // Butterfly k of stage s in plain arithmetic: groups of 2*half points, twiddle stride N/(2*half).
    function automatic txn_t bf_txn(int s, int k, int sel, int inv);
        txn_t t;
        int half, j, g;
        half   = 2 ** s;
        j      = k % half;
        g      = k / half;
        t.is_pw = 1'b0;
        t.top  = g * 2 * half + j;
        t.bot  = t.top + half;
        t.tw   = j * (N / (2 * half));
        t.addr = 0;
        t.sel  = sel;
        t.inv  = inv;
        return t;
    endfunction

    task automatic add_fft(input int sel, input int inv);
        for (int s = 0; s < LOG2N; s++)
            for (int k = 0; k < N / 2; k++)
                exp_q.push_back(bf_txn(s, k, sel, inv));
    endtask

    task automatic model_load();
        txn_t t;
        exp_q.delete();
        log_q.delete();
        trace_q.delete();
        add_fft(0, 0);
        add_fft(1, 0);
        for (int a = 0; a < N; a++) begin
            t = '{is_pw: 1'b1, top: 0, bot: 0, tw: 0, addr: a, sel: 2, inv: 0};
            exp_q.push_back(t);
        end
        add_fft(2, 1);
    endtask

    bit            chk_en = 1'b0;
    bit            stall_prev = 1'b0;
    bit            rand_rdy = 1'b0;
    int            done_cnt = 0;
    logic [AW-1:0] h_top, h_bot;
    logic [AW-2:0] h_tw;
    txn_t          cmp_e;
    int            cmp_code;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bf_ready = 1'($urandom_range(0, 1));
            pw_ready = 1'($urandom_range(0, 1));
        end
    end

    // Compare process: every transfer is checked against the head of the model queue.
    always @(negedge clk) begin
        if (chk_en) begin
            if (bf_valid && pw_valid) fail_now("both_valid");
            if (stall_prev) begin
                check("hold_valid", bf_valid, 1);
                check("hold_top", bf_top, h_top);
                check("hold_bot", bf_bot, h_bot);
                check("hold_tw", bf_tw, h_tw);
            end
            if (bf_valid || pw_valid) begin
                cmp_code = int'(buf_sel) * 2 + int'(bf_inv);
                if (trace_q.size() == 0 || trace_q[$] != cmp_code) trace_q.push_back(cmp_code);
            end
            if (bf_valid && bf_ready) begin
                if (exp_q.size() == 0) fail_now("bf_unexpected");
                else begin
                    cmp_e = exp_q.pop_front();
                    check("bf_kind", 0, cmp_e.is_pw);
                    check("bf_top", bf_top, cmp_e.top);
                    check("bf_bot", bf_bot, cmp_e.bot);
                    check("bf_tw", bf_tw, cmp_e.tw);
                    check("bf_sel", buf_sel, cmp_e.sel);
                    check("bf_inv", bf_inv, cmp_e.inv);
                end
                log_q.push_back('{is_pw: 1'b0, top: int'(bf_top), bot: int'(bf_bot), tw: int'(bf_tw),
                                  addr: 0, sel: int'(buf_sel), inv: int'(bf_inv)});
            end
            if (pw_valid && pw_ready) begin
                if (exp_q.size() == 0) fail_now("pw_unexpected");
                else begin
                    cmp_e = exp_q.pop_front();
                    check("pw_kind", 1, cmp_e.is_pw);
                    check("pw_addr", pw_addr, cmp_e.addr);
                    check("pw_sel", buf_sel, cmp_e.sel);
                    check("pw_inv", bf_inv, cmp_e.inv);
                end
                log_q.push_back('{is_pw: 1'b1, top: 0, bot: 0, tw: 0, addr: int'(pw_addr),
                                  sel: int'(buf_sel), inv: int'(bf_inv)});
            end
            stall_prev = bf_valid && !bf_ready;
            h_top = bf_top;
            h_bot = bf_bot;
            h_tw  = bf_tw;
            if (done) begin
                done_cnt++;
                check("done_model_empty", exp_q.size(), 0);
            end
        end
    end

    task automatic check_zero(input string p);
        check({p, "_busy"}, busy, 0);
        check({p, "_done"}, done, 0);
        check({p, "_bf_valid"}, bf_valid, 0);
        check({p, "_pw_valid"}, pw_valid, 0);
        check({p, "_buf_sel"}, buf_sel, 0);
        check({p, "_bf_inv"}, bf_inv, 0);
        check({p, "_bf_top"}, bf_top, 0);
        check({p, "_bf_bot"}, bf_bot, 0);
        check({p, "_bf_tw"}, bf_tw, 0);
        check({p, "_pw_addr"}, pw_addr, 0);
        check({p, "_stage"}, stage, 0);
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles after the start edge until done; optional start re-pulses while busy.
    task automatic run_to_done(input int budget, input bit repulse, output int cyc, output int busy_n);
        bit got;
        got = 1'b0;
        cyc = 0;
        busy_n = 0;
        while (!got && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_n++;
            if (done) got = 1'b1;
            start = repulse && (cyc == 10 || cyc == 30);
        end
        start = 1'b0;
        if (!got) fail_now("done_timeout");
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
    endtask

    int lit_top[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int lit_bot[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int lit_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    task automatic check_table(input string p);
        if (log_q.size() != 44) fail_now({p, "_log_size"});
        else begin
            for (int i = 0; i < 12; i++) begin
                check({p, "_lit_top"}, log_q[i].top, lit_top[i]);
                check({p, "_lit_bot"}, log_q[i].bot, lit_bot[i]);
                check({p, "_lit_tw"}, log_q[i].tw, lit_tw[i]);
            end
            for (int i = 0; i < N; i++) check({p, "_pw_seq"}, log_q[24 + i].addr, i);
            check({p, "_ifft_inv"}, log_q[32].inv, 1);
        end
    endtask

    int cyc, busy_n, waited;
    bit found;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Baseline run with everything ready.
        model_load();
        check("model_size", exp_q.size(), 44);
        check("model_s1k1_top", exp_q[5].top, 1);
        check("model_s1k1_tw", exp_q[5].tw, 2);
        check("model_s2k3_tw", exp_q[11].tw, 3);
        done_cnt = 0;
        chk_en = 1'b1;
        @(negedge clk);
        check_zero("idle");
        do_start();
        run_to_done(2000, 1'b0, cyc, busy_n);
        check("latency", cyc, 55);
        check("busy_cycles", busy_n, 55);
        repeat (3) @(negedge clk);
        check("done_count_1", done_cnt, 1);
        check("model_drained_1", exp_q.size(), 0);
        check_table("run1");
        check("trace_len", trace_q.size(), 4);
        if (trace_q.size() == 4) begin
            check("trace_a", trace_q[0], 0);
            check("trace_b", trace_q[1], 2);
            check("trace_pw", trace_q[2], 4);
            check("trace_ifft", trace_q[3], 5);
        end

        // Random back-pressure plus start re-pulses while busy.
        model_load();
        done_cnt = 0;
        rand_rdy = 1'b1;
        do_start();
        run_to_done(2000, 1'b1, cyc, busy_n);
        repeat (3) @(negedge clk);
        rand_rdy = 1'b0;
        @(posedge clk);
        #1 bf_ready = 1'b1;
        pw_ready = 1'b1;
        check("done_count_2", done_cnt, 1);
        check("model_drained_2", exp_q.size(), 0);
        check_table("run2");

        // Drain held off by dp_idle after stage 0.
        model_load();
        done_cnt = 0;
        dp_idle = 1'b0;
        do_start();
        found = 1'b0;
        waited = 0;
        while (!found && waited < 50) begin
            @(negedge clk);
            waited++;
            if (bf_valid && bf_ready && stage == 4'd0 && bf_top == 3'd6) found = 1'b1;
        end
        if (!found) fail_now("stage0_end_timeout");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("drain_no_bf", bf_valid, 0);
            check("drain_no_pw", pw_valid, 0);
            check("drain_busy", busy, 1);
        end
        @(posedge clk);
        #1 dp_idle = 1'b1;
        @(negedge clk);
        check("drain_exit_cycle", bf_valid, 0);
        @(negedge clk);
        check("s1_valid", bf_valid, 1);
        check("s1_top", bf_top, 0);
        check("s1_bot", bf_bot, 2);
        check("s1_tw", bf_tw, 0);
        check("s1_stage", stage, 1);
        run_to_done(2000, 1'b0, cyc, busy_n);
        repeat (2) @(negedge clk);
        check("done_count_3", done_cnt, 1);
        check("model_drained_3", exp_q.size(), 0);

        // Reset in the middle of the pointwise pass.
        model_load();
        done_cnt = 0;
        do_start();
        found = 1'b0;
        waited = 0;
        while (!found && waited < 200) begin
            @(negedge clk);
            waited++;
            if (pw_valid && pw_addr == 3'd3) found = 1'b1;
        end
        if (!found) fail_now("pw3_timeout");
        #1 chk_en = 1'b0;
        rst_n = 1'b0;
        #1 check_zero("mid_reset");
        @(negedge clk);
        check_zero("held_reset");
        check("no_done_on_abort", done_cnt, 0);
        rst_n = 1'b1;
        model_load();
        stall_prev = 1'b0;
        done_cnt = 0;
        chk_en = 1'b1;
        do_start();
        run_to_done(2000, 1'b0, cyc, busy_n);
        check("post_reset_latency", cyc, 55);
        repeat (2) @(negedge clk);
        check("done_count_4", done_cnt, 1);
        check("model_drained_4", exp_q.size(), 0);
        if (log_q.size() > 0) begin
            check("post_reset_top", log_q[0].top, 0);
            check("post_reset_bot", log_q[0].bot, 1);
            check("post_reset_tw", log_q[0].tw, 0);
        end else fail_now("post_reset_log_empty");

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_mul_sequencer.md
Name: fft_mul_sequencer

Overview:
- Control sequencer for the FFT-based 1024-bit large multiplier.
- Runs one full multiply in five steps:
  - forward FFT of operand A
  - forward FFT of operand B
  - pointwise complex multiply
  - inverse FFT of the product
  - completion
- Drives the butterfly datapath: in-place radix-2 addresses, twiddle index, buffer select and inverse flag.
- Drives the pointwise unit.
- Waits for the datapath pipeline to drain between stages.

Parameters:
- LOG2N, 9, log2 of transform length N. N=512 points covers 2048 product bits at 4-bit digits.
- ADDR_W, LOG2N, width of point addresses.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a multiply; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the multiply completes
- buf_sel  out  2  data buffer: 0=A, 1=B, 2=product
- bf_inv  out  1  1 during the inverse FFT (conjugate twiddles); 0 otherwise
- bf_valid  out  1  butterfly request valid
- bf_ready  in  1  butterfly unit accepts the request
- bf_top  out  ADDR_W  upper butterfly point address
- bf_bot  out  ADDR_W  lower butterfly point address
- bf_tw  out  ADDR_W-1  twiddle ROM index
- pw_valid  out  1  pointwise request valid
- pw_ready  in  1  pointwise unit accepts the request
- pw_addr  out  ADDR_W  point index for pointwise multiply
- dp_idle  in  1  butterfly and pointwise pipelines are empty
- stage  out  4  current FFT stage s, for debug

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all counters cleared.
  - busy=0, done=0, bf_valid=0, pw_valid=0, buf_sel=0, bf_inv=0.
  - bf_top, bf_bot, bf_tw, pw_addr, stage all 0.
- Reset mid-operation: abandons the multiply immediately. No done pulse. Datapath contents are don't-care.
- States: IDLE, FFT_A, FFT_B, PW, IFFT, DRAIN, FIN.
- IDLE:
  - start=1 → FFT_A with s=0, k=0.
  - First request is presented in the next cycle.
  - start in any other state is ignored.
- Butterfly states (FFT_A buf_sel=0; FFT_B buf_sel=1; IFFT buf_sel=2, bf_inv=1):
  - bf_valid=1. Stage s = 0..LOG2N-1, butterfly k = 0..N/2-1.
  - half = 1<<s; j = k & (half-1); g = k>>s.
  - bf_top = g*2*half + j; bf_bot = bf_top + half; bf_tw = j << (LOG2N-1-s).
  - k advances only on bf_valid & bf_ready. Outputs hold stable while bf_ready=0.
  - On transfer with k=N/2-1: bf_valid drops next cycle; go to DRAIN.
- PW:
  - buf_sel=2, pw_valid=1, pw_addr=k for k = 0..N-1.
  - k advances on pw_valid & pw_ready.
  - Last transfer → DRAIN.
- DRAIN:
  - No requests; occupies at least one cycle; exits on the first cycle with dp_idle=1.
  - Exit target:
    - next stage of the same pass, with k=0;
    - after the last stage of FFT_A → FFT_B;
    - after the last stage of FFT_B → PW;
    - after PW → IFFT, s=0;
    - after the last IFFT stage → FIN.
  - buf_sel and bf_inv hold their pass values throughout DRAIN.
- FIN: done=1 for exactly one cycle; → IDLE; busy=0 in the following cycle.
- Counters:
  - k is LOG2N bits wide (LOG2N-1 in butterfly passes); wraps to 0 at each stage boundary.
  - s saturates; never exceeds LOG2N-1.
- Latency with bf_ready, pw_ready, dp_idle all constant 1:
  - each FFT pass = LOG2N*(N/2+1) cycles; PW = N+1 cycles.
  - done asserted 3*LOG2N*(N/2+1)+N+2 cycles after the start edge.
- Simultaneous events: a transfer on the last butterfly/point and dp_idle=1 in the same cycle still passes through DRAIN for at least one cycle.

Test Plan:
- LOG2N=3; reset, start=1 for one cycle; ready/idle tied to 1.
  - Stage 0 issues (top,bot,tw) = (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - Stage 1 issues (0,2,0) (1,3,2) (4,6,0) (5,7,2).
  - Stage 2 issues (0,4,0) (1,5,1) (2,6,2) (3,7,3).
  - done pulses exactly 55 cycles after start; busy high for 55 cycles.
- LOG2N=3; bf_ready toggled randomly → address sequence identical to the test above; bf_top/bf_bot/bf_tw never change while bf_valid=1 and bf_ready=0.
- dp_idle held 0 for 10 cycles after the last stage-0 butterfly → no request issued during that time; stage-1 request (0,2,0) appears in the cycle after dp_idle rises.
- Trace buf_sel/bf_inv across a run → sequence 0/0, 1/0, 2/0 (PW, pw_addr 0..7), 2/1 (IFFT).
- Re-pulse start while busy → ignored; exactly one done pulse occurs.
- rst_n low during PW at pw_addr=3 → all outputs zero at once; after release, start runs a clean full sequence from (0,1,0).
